// File: rtl/fc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_seq_pkg
// Description : Shared constants, state encoding and accumulator type for the
//               fully-connected layer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_seq_pkg;

    localparam int c_IN_LEN   = 225;  // flattened features per neuron
    localparam int c_NUM_OUT  = 10;   // output neurons
    localparam int c_DATA_W   = 22;   // signed feature width
    localparam int c_WEIGHT_W = 8;    // signed weight width
    localparam int c_BIAS_W   = 22;   // signed bias width
    localparam int c_IDX_W    = 8;    // feature index width
    localparam int c_ADDR_W   = 12;   // weight ROM address width
    localparam int c_ACC_W    = 38;   // accumulator width (DATA_W+WEIGHT_W+8)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    typedef logic signed [c_ACC_W-1:0] acc_t;

endpackage : fc_seq_pkg
`default_nettype wire

// File: rtl/fc_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : fc_mac_unit
// Description : Multiply-accumulate datapath for one dense-layer neuron.
//               The feature is registered on issue so it meets the weight,
//               which arrives one cycle after its address. finalize_i loads
//               the result register with acc + last product + bias.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               issue_i         - a feature/address pair is issued this cycle
//               finalize_i      - form the neuron result this cycle
//               clear_i         - zero the accumulator
//               feature_i       - buffer element for the issued index
//               weight_i        - ROM weight for the previous cycle's address
//               bias_i          - bias for the current neuron
//               result_o        - registered neuron result
// Revision    : 1.0 - initial release
// ============================================================================
module fc_mac_unit #(
    parameter int DATA_W   = 22,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 22,
    parameter int ACC_W    = 38
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_i,
    input  logic                     finalize_i,
    input  logic                     clear_i,
    input  logic signed [DATA_W-1:0]   feature_i,
    input  logic signed [WEIGHT_W-1:0] weight_i,
    input  logic signed [BIAS_W-1:0]   bias_i,
    output logic signed [ACC_W-1:0]    result_o
);

    localparam int PROD_W = DATA_W + WEIGHT_W;

    logic signed [DATA_W-1:0] feature_q;
    logic                     pend_q;      // feature_q holds an unconsumed issue
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  result_q;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_term;

    // Both operands widened to the full product width before multiplying
    assign w_prod = $signed({{WEIGHT_W{feature_q[DATA_W-1]}}, feature_q})
                  * $signed({{DATA_W{weight_i[WEIGHT_W-1]}}, weight_i});
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    assign w_term     = pend_q ? w_prod_ext : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            feature_q <= '0;
            pend_q    <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            pend_q <= issue_i;
            if (issue_i) begin
                feature_q <= feature_i;
            end
            if (clear_i) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_q + w_term;
            end
            if (finalize_i) begin
                result_q <= acc_q + w_term + w_bias_ext;
            end
        end
    end

    assign result_o = result_q;

endmodule : fc_mac_unit
`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc_layer_sequencer
// Description : Sequences the dense layer after the flatten buffer. Walks
//               every neuron over all features, drives buffer index and
//               weight ROM address, and hands each neuron result downstream
//               over a valid/ready handshake.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_start            - flatten buffer full (sampled in IDLE)
//               o_feature_idx      - buffer read index
//               i_feature          - buffer element at o_feature_idx
//               o_weight_addr      - weight ROM address
//               i_weight           - ROM data, one cycle after address
//               o_neuron_idx       - current neuron / bias ROM address
//               i_bias             - bias, one cycle after o_neuron_idx
//               o_result           - neuron output
//               o_result_valid     - o_result valid
//               i_result_ready     - downstream accepts result
//               o_busy             - not idle
//               o_done             - pass complete pulse
//               o_buffer_clear     - re-arm pulse for the flatten buffer
// Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int IN_LEN   = c_IN_LEN,
    parameter int NUM_OUT  = c_NUM_OUT,
    parameter int DATA_W   = c_DATA_W,
    parameter int WEIGHT_W = c_WEIGHT_W,
    parameter int BIAS_W   = c_BIAS_W,
    parameter int IDX_W    = c_IDX_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int ACC_W    = c_ACC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    output logic [IDX_W-1:0]           o_feature_idx,
    input  logic signed [DATA_W-1:0]   i_feature,
    output logic [ADDR_W-1:0]          o_weight_addr,
    input  logic signed [WEIGHT_W-1:0] i_weight,
    output logic [3:0]                 o_neuron_idx,
    input  logic signed [BIAS_W-1:0]   i_bias,
    output logic signed [ACC_W-1:0]    o_result,
    output logic                       o_result_valid,
    input  logic                       i_result_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_buffer_clear
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [3:0]        neuron_q, neuron_d;
    logic [ADDR_W-1:0] base_q, base_d;     // neuron*IN_LEN, stepped per neuron
    logic              valid_q, valid_d;

    logic w_issue;
    logic w_finalize;
    logic w_clear;
    logic w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            neuron_q <= '0;
            base_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            neuron_q <= neuron_d;
            base_q   <= base_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        neuron_d   = neuron_q;
        base_d     = base_q;
        valid_d    = valid_q;
        w_issue    = 1'b0;
        w_finalize = 1'b0;
        w_clear    = 1'b0;
        w_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d  = ST_ISSUE;
                    k_d      = '0;
                    neuron_d = '0;
                    base_d   = '0;
                    w_clear  = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (k_q == IDX_W'(IN_LEN - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                w_finalize = 1'b1;
                valid_d    = 1'b1;
                state_d    = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                // Index and address stay frozen while the result is stalled
                if (i_result_ready) begin
                    valid_d = 1'b0;
                    w_clear = 1'b1;
                    k_d     = '0;
                    if (neuron_q == 4'(NUM_OUT - 1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        neuron_d = neuron_q + 1'b1;
                        base_d   = base_q + ADDR_W'(IN_LEN);
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    fc_mac_unit #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .BIAS_W   (BIAS_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (w_issue),
        .finalize_i (w_finalize),
        .clear_i    (w_clear),
        .feature_i  (i_feature),
        .weight_i   (i_weight),
        .bias_i     (i_bias),
        .result_o   (o_result)
    );

    assign o_feature_idx  = k_q;
    assign o_weight_addr  = base_q + ADDR_W'(k_q);
    assign o_neuron_idx   = neuron_q;
    assign o_result_valid = valid_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_done         = w_done;
    assign o_buffer_clear = w_done;

endmodule : fc_layer_sequencer
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_layer_sequencer
// Description : Directed self-checking bench for fc_layer_sequencer with a
//               combinational feature buffer and registered weight/bias ROMs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_layer_sequencer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_start = 1'b0;
    logic [7:0]         o_feature_idx;
    logic signed [21:0] i_feature;
    logic [11:0]        o_weight_addr;
    logic signed [7:0]  i_weight = '0;
    logic [3:0]         o_neuron_idx;
    logic signed [21:0] i_bias = '0;
    logic signed [37:0] o_result;
    logic               o_result_valid;
    logic               i_result_ready = 1'b1;
    logic               o_busy;
    logic               o_done;
    logic               o_buffer_clear;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    logic signed [63:0] exp_res [10];

    always #5 clk = ~clk;

    fc_layer_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .o_feature_idx  (o_feature_idx),
        .i_feature      (i_feature),
        .o_weight_addr  (o_weight_addr),
        .i_weight       (i_weight),
        .o_neuron_idx   (o_neuron_idx),
        .i_bias         (i_bias),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_buffer_clear (o_buffer_clear)
    );

    // Stimulus content per mode:
    // 0: f=1, w=1, b=0   1: f=k, w=1, b=n   2: f=-2^21, w=-128, b=0
    // 3: mixed-sign patterns
    function automatic logic signed [21:0] ffun(input int m, input int k);
        case (m)
            0:       return 22'sd1;
            1:       return 22'(k);
            2:       return -22'sd2097152;
            default: return 22'(((k * 37) % 101) - 50);
        endcase
    endfunction

    function automatic logic signed [7:0] wfun(input int m, input int a);
        case (m)
            0, 1:    return 8'sd1;
            2:       return -8'sd128;
            default: return 8'((a % 13) - 6);
        endcase
    endfunction

    function automatic logic signed [21:0] bfun(input int m, input int n);
        case (m)
            1:       return 22'(n);
            3:       return 22'(n * 1000 - 4000);
            default: return 22'sd0;
        endcase
    endfunction

    always_comb i_feature = ffun(mode, int'(o_feature_idx));

    always @(posedge clk) begin
        i_weight <= wfun(mode, int'(o_weight_addr));
        i_bias   <= bfun(mode, int'(o_neuron_idx));
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_expected(input int m);
        for (int n = 0; n < 10; n++) begin
            case (m)
                0: exp_res[n] = 64'sd225;
                1: exp_res[n] = 64'sd25200 + 64'(n);
                2: exp_res[n] = 64'sd60397977600;
                default: begin
                    int fv, wv;
                    exp_res[n] = 64'(int'(bfun(m, n)));
                    for (int k = 0; k < 225; k++) begin
                        fv = int'(ffun(m, k));
                        wv = int'(wfun(m, n * 225 + k));
                        exp_res[n] = exp_res[n] + 64'(fv * wv);
                    end
                end
            endcase
        end
    endtask

    // One full pass. stall_n: neuron held off for 5 cycles (-1 none);
    // pulse_n: neuron during whose ISSUE a stray i_start is pulsed (-1 none).
    task automatic run_pass(input int m, input int stall_n, input int pulse_n);
        int total, cyc, rise0;
        logic signed [63:0] held_res;
        logic [11:0] held_addr;
        mode = m;
        set_expected(m);
        @(negedge clk) i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        total = 1;   // the edge that sampled i_start counts as cycle 1
        rise0 = 0;
        for (int n = 0; n < 10; n++) begin
            if (n == stall_n) i_result_ready = 1'b0;
            if (n == pulse_n) begin
                i_start = 1'b1;
                @(posedge clk); #1; total++;
                i_start = 1'b0;
            end
            cyc = 0;
            while (!o_result_valid && cyc < 1000) begin
                @(posedge clk); #1; total++; cyc++;
            end
            if (cyc >= 1000) begin
                check("valid_timeout", 64'(n), -64'sd1);
                i_result_ready = 1'b1;
                return;
            end
            if (n == 0) begin
                check("first_latency", 64'(total), 64'sd227);
                rise0 = total;
            end
            if (n == 1) check("neuron_period", 64'(total - rise0), 64'sd227);
            check($sformatf("result_m%0d_n%0d", m, n), 64'(o_result), exp_res[n]);
            check("neuron_idx", 64'(o_neuron_idx), 64'(n));
            if (n == stall_n) begin
                held_res  = 64'(o_result);
                held_addr = o_weight_addr;
                repeat (5) begin
                    @(posedge clk); #1; total++;
                end
                check("stall_valid", 64'(o_result_valid), 64'sd1);
                check("stall_result", 64'(o_result), held_res);
                check("stall_addr", 64'(o_weight_addr), 64'(held_addr));
                i_result_ready = 1'b1;
            end
            @(posedge clk); #1; total++;
            check("valid_drop", 64'(o_result_valid), 64'sd0);
            if (n == stall_n && n < 9) begin
                check("next_neuron", 64'(o_neuron_idx), 64'(n + 1));
                check("next_addr", 64'(o_weight_addr), 64'((n + 1) * 225));
            end
        end
        check("done_pulse", 64'(o_done), 64'sd1);
        check("buffer_clear", 64'(o_buffer_clear), 64'sd1);
        @(posedge clk); #1;
        check("done_low", 64'(o_done), 64'sd0);
        check("idle_busy", 64'(o_busy), 64'sd0);
        repeat (3) @(posedge clk);
        #1 check("no_extra_pass", 64'(o_busy | o_result_valid), 64'sd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_result"}, 64'(o_result), 64'sd0);
        check({tag, "_valid"}, 64'(o_result_valid), 64'sd0);
        check({tag, "_busy"}, 64'(o_busy), 64'sd0);
        check({tag, "_done"}, 64'(o_done), 64'sd0);
        check({tag, "_clear"}, 64'(o_buffer_clear), 64'sd0);
        check({tag, "_fidx"}, 64'(o_feature_idx), 64'sd0);
        check({tag, "_waddr"}, 64'(o_weight_addr), 64'sd0);
        check({tag, "_nidx"}, 64'(o_neuron_idx), 64'sd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", 64'(o_busy), 64'sd0);

        run_pass(0, 3, -1);   // unit data, backpressure on neuron 3
        run_pass(1, -1, 2);   // ramp data, stray start during neuron 2
        run_pass(2, -1, -1);  // worst-case magnitude

        // Reset in the middle of neuron 5, feature 100
        mode = 3;
        @(negedge clk) i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 0;
        while (!(o_neuron_idx == 4'd5 && o_feature_idx == 8'd100) && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        check("reach_n5_k100", 64'(cyc < 3000), 64'sd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("midrst");
        rst = 1'b0;

        run_pass(3, -1, -1);  // fresh pass after reset, mixed-sign data

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fc_layer_sequencer
`default_nettype wire
